// File: rtl/alu_mem_arbiter.sv
// Round-robin arbiter that funnels execution-unit memory requests onto one RAM port.
// Define ALU_ARB_TIMEOUT_EN to build the ISSUE-state bus timeout (limit TMO cycles).
module alu_mem_arbiter #(
    parameter int unsigned NCH = 8,
    parameter int unsigned AW  = 8,
    parameter int unsigned DW  = 32,
    parameter int unsigned TMO = 15
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [NCH-1:0]    iREQ,
    input  logic [NCH-1:0]    iWR,
    input  logic [NCH*AW-1:0] iADDR,
    input  logic [NCH*DW-1:0] iWDATA,
    output logic [NCH-1:0]    oACK,
    output logic              oERR,
    output logic [DW-1:0]     oRDATA,
    output logic [NCH-1:0]    oGNT,
    output logic              oBUSY,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [AW-1:0]     oRAM_ADDR,
    output logic [DW-1:0]     oRAM_DATA,
    input  logic [DW-1:0]     iRAM_DATA,
    input  logic              iRAM_RDY
);
    localparam int unsigned    IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0]  LAST_RST = IW'(NCH - 1);
    localparam logic [NCH-1:0] ONE      = NCH'(1);

    if (NCH < 2 || NCH > 16 || TMO < 1) begin : g_bad_params
        $error("alu_mem_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win, cand;
    logic            found, finish;
    logic [NCH-1:0]  gnt_q, gnt_d, ack_q, ack_d;
    logic            busy_q, busy_d, ce_q, ce_d, rd_q, rd_d, we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = '0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = IW'((32'(last_q) + i) % NCH);
            if (!found && iREQ[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        busy_d  = busy_q;
        ce_d    = ce_q;
        rd_d    = rd_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        finish  = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StIssue;
                    last_d  = win;
                    gnt_d   = ONE << win;
                    busy_d  = 1'b1;
                    ce_d    = 1'b1;
                    rd_d    = ~iWR[win];
                    we_d    = iWR[win];
                    addr_d  = iADDR[32'(win) * AW +: AW];
                    wdata_d = iWDATA[32'(win) * DW +: DW];
`ifdef ALU_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StIssue: begin
                finish = iRAM_RDY;
`ifdef ALU_ARB_TIMEOUT_EN
                // A ready arriving on the limit cycle still counts as a good completion.
                if (!iRAM_RDY && cnt_q == CW'(TMO - 1)) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end
                if (!finish) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (finish) begin
                    state_d = StDone;
                    ack_d   = gnt_q;
                    rdata_d = (we_q || !iRAM_RDY) ? '0 : iRAM_DATA;
                    ce_d    = 1'b0;
                    rd_d    = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= StIdle;
            last_q  <= LAST_RST;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ce_q    <= ce_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign oACK      = ack_q;
    assign oRDATA    = rdata_q;
    assign oGNT      = gnt_q;
    assign oBUSY     = busy_q;
    assign oRAM_CE   = ce_q;
    assign oRAM_RD   = rd_q;
    assign oRAM_WR   = we_q;
    assign oRAM_ADDR = addr_q;
    assign oRAM_DATA = wdata_q;
`ifdef ALU_ARB_TIMEOUT_EN
    assign oERR      = err_q;
`else
    assign oERR      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mem_arbiter.sv
// Directed scoreboard bench for alu_mem_arbiter; requesters drop after ack and may re-request.
module tb_alu_mem_arbiter;
    localparam int NCH = 8;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req, wr;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH-1:0]    ack, gnt;
    logic              err, busy, ram_ce, ram_rd, ram_wr, rdy;
    logic [DW-1:0]     rdata, ram_wdata, ram_data;
    logic [AW-1:0]     ram_addr;

    always #5 clk = ~clk;

    alu_mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .iCLK(clk), .iRST(rst), .iREQ(req), .iWR(wr), .iADDR(addr), .iWDATA(wdata),
        .oACK(ack), .oERR(err), .oRDATA(rdata), .oGNT(gnt), .oBUSY(busy),
        .oRAM_CE(ram_ce), .oRAM_RD(ram_rd), .oRAM_WR(ram_wr), .oRAM_ADDR(ram_addr),
        .oRAM_DATA(ram_wdata), .iRAM_DATA(ram_data), .iRAM_RDY(rdy)
    );

    typedef struct packed {
        logic [NCH-1:0] ack;
        logic [DW-1:0]  rdata;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   ack_cyc[$];
    int   n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0, ack_count = 0;
    int   remaining[NCH];
    int   rearm_at[NCH];
    logic ram_auto;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs, score acks, then model requesters and the RAM.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ack != '0) begin
            ack_count++;
            ack_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("ack_unexpected", 64'(ack), 64'd0);
            end else begin
                exp_t e = sb.pop_front();
                check("ack", 64'(ack), 64'(e.ack));
                check("rdata", 64'(rdata), 64'(e.rdata));
                check("err", 64'(err), 64'(e.err));
            end
            for (int k = 0; k < NCH; k++) begin
                if (ack[k]) begin
                    req[k] = 1'b0;
                    if (remaining[k] > 0) remaining[k]--;
                    if (remaining[k] > 0) rearm_at[k] = cyc + 2;
                end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (rearm_at[k] == cyc) begin
                req[k]      = 1'b1;
                rearm_at[k] = -1;
            end
        end
        if (ram_auto) ram_data = 32'hA5A5_0000 | {24'd0, ram_addr};
    endtask

    task automatic drain(string tag, int limit);
        int n = 0;
        while ((sb.size() != 0 || busy || req != '0) && n < limit) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 64'(n < limit), 64'd1);
    endtask

    task automatic check_spacing(string tag, int n_acks);
        check({tag, "_acks"}, 64'(ack_cyc.size()), 64'(n_acks));
        for (int i = 1; i < ack_cyc.size(); i++) begin
            check({tag, "_spacing"}, 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd3);
        end
    endtask

    initial begin
        int a0;
        int c0;
        int busy_n;
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
        rdy = 1'b0; ram_data = '0; ram_auto = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            remaining[k] = 0;
            rearm_at[k]  = -1;
        end
        repeat (3) step();
        check("reset_ctrl", 64'({ack, gnt, err, busy, ram_ce, ram_rd, ram_wr, ram_addr}), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_ram_data", 64'(ram_wdata), 64'd0);
        rst = 1'b0;

        // Single read on ch2, RAM ready immediately.
        addr[2*AW +: AW] = 8'h10; wr[2] = 1'b0; remaining[2] = 1; req[2] = 1'b1;
        rdy = 1'b1; ram_data = 32'hDEAD_BEEF;
        sb.push_back('{ack: 8'h04, rdata: 32'hDEAD_BEEF, err: 1'b0});
        step();
        check("rd_strobes", 64'({ram_ce, ram_rd, ram_wr}), 64'b110);
        check("rd_addr", 64'(ram_addr), 64'h10);
        check("rd_gnt", 64'(gnt), 64'h04);
        check("rd_busy", 64'(busy), 64'd1);
        step();
        check("rd_done_strobes", 64'({ram_ce, ram_rd, ram_wr}), 64'd0);
        check("rd_done_busy", 64'(busy), 64'd1);
        step();
        check("rd_idle", 64'({busy, gnt}), 64'd0);

        // Write on ch5 with four wait states; later wdata changes must not leak through.
        rdy = 1'b0; ram_data = 32'hCAFE_F00D;
        addr[5*AW +: AW] = 8'h55; wr[5] = 1'b1; wdata[5*DW +: DW] = 32'h1234_5678;
        remaining[5] = 1; req[5] = 1'b1; a0 = ack_count;
        sb.push_back('{ack: 8'h20, rdata: 32'h0, err: 1'b0});
        for (int i = 1; i <= 5; i++) begin
            step();
            check("wr_strobes", 64'({ram_ce, ram_rd, ram_wr}), 64'b101);
            check("wr_data", 64'(ram_wdata), 64'h1234_5678);
            check("wr_addr", 64'(ram_addr), 64'h55);
            if (i == 2) wdata[5*DW +: DW] = 32'h0BAD_F00D;
            rdy = (i == 5);
        end
        step();
        rdy = 1'b0;
        drain("wr", 20);
        check("wr_one_ack", 64'(ack_count - a0), 64'd1);

        // Fairness from reset between ch0 and ch3.
        rst = 1'b1; step(); rst = 1'b0;
        ack_cyc.delete();
        ram_auto = 1'b1; rdy = 1'b1; wr = '0;
        addr[0*AW +: AW] = 8'h40; addr[3*AW +: AW] = 8'h43;
        remaining[0] = 2; remaining[3] = 2;
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{ack: 8'h01, rdata: 32'hA5A5_0040, err: 1'b0});
            sb.push_back('{ack: 8'h08, rdata: 32'hA5A5_0043, err: 1'b0});
        end
        req[0] = 1'b1; req[3] = 1'b1;
        drain("fair", 60);
        check_spacing("fair", 4);

        // All channels requesting: two full rounds, odd channels write.
        rst = 1'b1; step(); rst = 1'b0;
        ack_cyc.delete();
        for (int k = 0; k < NCH; k++) begin
            addr[k*AW +: AW]  = 8'(8'h80 + k);
            wr[k]             = (k % 2 == 1);
            wdata[k*DW +: DW] = 32'h1000 + k;
            remaining[k]      = 2;
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NCH; k++) begin
                exp_t e;
                e.ack   = 8'(1 << k);
                e.rdata = (k % 2 == 1) ? 32'h0 : 32'hA5A5_0080 + k;
                e.err   = 1'b0;
                sb.push_back(e);
            end
        end
        req = '1;
        drain("all8", 200);
        check_spacing("all8", 16);

        // Reset in the middle of a ch1 read: no ack, pointer restored.
        ram_auto = 1'b0; rdy = 1'b0; wr = '0;
        addr[1*AW +: AW] = 8'h21; addr[4*AW +: AW] = 8'h24;
        remaining[1] = 1; req[1] = 1'b1; a0 = ack_count;
        step();
        check("abort_issue", 64'({ram_ce, gnt}), 64'({1'b1, 8'h02}));
        step();
        rst = 1'b1;
        step();
        check("abort_reset_ctrl", 64'({ack, gnt, err, busy, ram_ce, ram_rd, ram_wr, ram_addr}),
              64'd0);
        check("abort_reset_data", 64'({rdata, ram_wdata}), 64'd0);
        check("abort_no_ack", 64'(ack_count - a0), 64'd0);
        rst = 1'b0; remaining[4] = 1; req[4] = 1'b1; ram_auto = 1'b1; rdy = 1'b1;
        sb.push_back('{ack: 8'h02, rdata: 32'hA5A5_0021, err: 1'b0});
        sb.push_back('{ack: 8'h10, rdata: 32'hA5A5_0024, err: 1'b0});
        step();
        check("post_reset_gnt", 64'(gnt), 64'h02);
        drain("abort", 40);

        // RAM never ready.
        ram_auto = 1'b0; rdy = 1'b0; ram_data = 32'hFFFF_FFFF;
        addr[6*AW +: AW] = 8'h66; wr[6] = 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
        ack_cyc.delete();
        remaining[6] = 1; req[6] = 1'b1; c0 = cyc;
        sb.push_back('{ack: 8'h40, rdata: 32'h0, err: 1'b1});
        for (int i = 1; i <= 4; i++) begin
            step();
            check("tmo_busy", 64'({busy, ram_ce}), 64'b11);
        end
        step();
        check("tmo_latency", 64'((ack_cyc.size() == 1) ? ack_cyc[0] - c0 : -1), 64'd5);
        drain("tmo", 20);
        // Ready on the limit cycle wins over the timeout.
        remaining[6] = 1; req[6] = 1'b1;
        sb.push_back('{ack: 8'h40, rdata: 32'hFFFF_FFFF, err: 1'b0});
        for (int i = 1; i <= 4; i++) begin
            step();
            rdy = (i == 4);
        end
        step();
        rdy = 1'b0;
        drain("tmo_race", 20);
        busy_n = 0;
`else
        remaining[6] = 1; req[6] = 1'b1; a0 = ack_count; busy_n = 0; c0 = cyc;
        repeat (100) begin
            step();
            if (busy) busy_n++;
        end
        check("no_tmo_busy", 64'(busy_n), 64'd100);
        check("no_tmo_ack", 64'(ack_count - a0), 64'd0);
        check("no_tmo_cycles", 64'(cyc - c0), 64'd100);
        sb.push_back('{ack: 8'h40, rdata: 32'hA5A5_0066, err: 1'b0});
        ram_data = 32'hA5A5_0066; rdy = 1'b1;
        drain("no_tmo", 10);
        rdy = 1'b0;
`endif

        drain("final", 20);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
